ctrl_hazard_unit: RTL and testbench

- Second-generation decode/control unit for the 5-stage RISC-V pipeline.
- Decodes the ID-stage instruction into a control bundle and detects load-use hazards internally; stall is no longer an external input.
- Sequences multi-cycle M-extension ops with a counter FSM, applies branch flush, and registers the bundle into the ID/EX control stage.
- Sits between the IF/ID register and the EX stage; drives PC and IF/ID write-enables.

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ctrl_decode.sv | 52 +++++
 rtl/ctrl_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_ctrl_hazard_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle type for the ID-stage decode/hazard unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   branch;
        logic   jump;
        logic   memtoreg;
        aluop_e aluop;
        logic   memwrite;
        logic   memread;
        logic   alusrc;
        logic   regwrite;
        logic   mul;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 decoder producing the ID-stage control bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [6:0]      funct7_i,
    output ctrl_bundle_t    ctrl_o
);

    // NOTE: default assigned first so every path drives ctrl_o and no latch is inferred.
    always_comb begin
        ctrl_o = CTRL_BUBBLE;
        case (op_i)
            OP_W'(OP_R): begin
                ctrl_o.aluop    = ALUOP_R;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.mul      = (funct7_i == FUNCT7_MULDIV);
            end
            OP_W'(OP_I): begin
                ctrl_o.aluop    = ALUOP_I;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            OP_W'(OP_LD): begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.memread  = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            OP_W'(OP_ST): begin
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
            end
            OP_W'(OP_BR): begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = ALUOP_BR;
            end
            OP_W'(OP_JAL): begin
                ctrl_o.jump     = 1'b1;
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            default: ctrl_o = CTRL_BUBBLE;
        endcase
    end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Decode + load-use/multi-cycle hazard control and ID/EX control register.
// Define CTRL_PERF_CNT_EN to add stall/flush performance counters.
module ctrl_hazard_unit
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 7,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [6:0]        funct7_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_memread_i,
    input  logic              flush_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic              ex_memtoreg_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_memwrite_o,
    output logic              ex_memread_o,
    output logic              ex_alusrc_o,
    output logic              ex_regwrite_o,
    output logic              ex_mul_o,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic              busy_o
);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_e;

    localparam bit MUL_MULTI = (MUL_LAT > 1);

    ctrl_bundle_t      dec;
    ctrl_bundle_t      ex_q, ex_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              use_rs1, use_rs2, lu, hold, busy;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_i     (op_i),
        .funct7_i (funct7_i),
        .ctrl_o   (dec)
    );

    // JAL reads no sources; I-type and loads read rs1 only.
    assign use_rs1 = (op_i != OP_W'(OP_JAL));
    assign use_rs2 = (op_i != OP_W'(OP_I)) && (op_i != OP_W'(OP_LD)) && (op_i != OP_W'(OP_JAL));

    assign lu = ex_memread_i && (ex_rd_i != '0) &&
                ((use_rs1 && (ex_rd_i == rs1_i)) || (use_rs2 && (ex_rd_i == rs2_i)));

    assign busy         = (state_q == MUL_BUSY);
    assign hold         = lu || busy || mem_stall_i;
    assign pc_write_o   = ~hold;
    assign ifid_write_o = ~hold;
    assign busy_o       = busy;

    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mem_stall_i) begin
            if (flush_i || lu || busy) begin
                ex_d = CTRL_BUBBLE;
            end else begin
                ex_d = dec;
            end
            case (state_q)
                IDLE: begin
                    if (MUL_MULTI && dec.mul && !flush_i && !lu) begin
                        state_d = MUL_BUSY;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
                MUL_BUSY: begin
                    // The mul is already in EX, so a flush does not stop the count.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments; reset here is synchronous, sampled on the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q    <= CTRL_BUBBLE;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hold)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

    assign ex_branch_o   = ex_q.branch;
    assign ex_jump_o     = ex_q.jump;
    assign ex_memtoreg_o = ex_q.memtoreg;
    assign ex_aluop_o    = ex_q.aluop;
    assign ex_memwrite_o = ex_q.memwrite;
    assign ex_memread_o  = ex_q.memread;
    assign ex_alusrc_o   = ex_q.alusrc;
    assign ex_regwrite_o = ex_q.regwrite;
    assign ex_mul_o      = ex_q.mul;

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Directed self-checking bench for ctrl_hazard_unit (default MUL_LAT=4).
module tb_ctrl_hazard_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] op_i = 7'd0;
    logic [6:0] funct7_i = 7'd0;
    logic [4:0] rs1_i = 5'd0, rs2_i = 5'd0, ex_rd_i = 5'd0;
    logic       ex_memread_i = 1'b0, flush_i = 1'b0, mem_stall_i = 1'b0;
    logic       pc_write_o, ifid_write_o, busy_o;
    logic       ex_branch_o, ex_jump_o, ex_memtoreg_o, ex_memwrite_o;
    logic       ex_memread_o, ex_alusrc_o, ex_regwrite_o, ex_mul_o;
    logic [1:0] ex_aluop_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    // {branch,jump,memtoreg,aluop[1:0],memwrite,memread,alusrc,regwrite,mul}
    localparam logic [9:0] V_BUB = 10'b0_0_0_00_0_0_0_0_0;
    localparam logic [9:0] V_R   = 10'b0_0_0_10_0_0_0_1_0;
    localparam logic [9:0] V_MUL = 10'b0_0_0_10_0_0_0_1_1;
    localparam logic [9:0] V_I   = 10'b0_0_0_11_0_0_1_1_0;
    localparam logic [9:0] V_LD  = 10'b0_0_1_00_0_1_1_1_0;
    localparam logic [9:0] V_ST  = 10'b0_0_0_00_1_0_1_0_0;
    localparam logic [9:0] V_BR  = 10'b1_0_0_01_0_0_0_0_0;
    localparam logic [9:0] V_JAL = 10'b0_1_0_00_0_0_1_1_0;

    logic [9:0] ex_vec;
    assign ex_vec = {ex_branch_o, ex_jump_o, ex_memtoreg_o, ex_aluop_o, ex_memwrite_o,
                     ex_memread_o, ex_alusrc_o, ex_regwrite_o, ex_mul_o};

    ctrl_hazard_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .op_i          (op_i),
        .funct7_i      (funct7_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .ex_rd_i       (ex_rd_i),
        .ex_memread_i  (ex_memread_i),
        .flush_i       (flush_i),
        .mem_stall_i   (mem_stall_i),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .ex_branch_o   (ex_branch_o),
        .ex_jump_o     (ex_jump_o),
        .ex_memtoreg_o (ex_memtoreg_o),
        .ex_aluop_o    (ex_aluop_o),
        .ex_memwrite_o (ex_memwrite_o),
        .ex_memread_o  (ex_memread_o),
        .ex_alusrc_o   (ex_alusrc_o),
        .ex_regwrite_o (ex_regwrite_o),
        .ex_mul_o      (ex_mul_o),
`ifdef CTRL_PERF_CNT_EN
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge; registered outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [6:0] f7,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        op_i = op; funct7_i = f7; rs1_i = rs1; rs2_i = rs2;
        #1;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic memread);
        ex_rd_i = rd; ex_memread_i = memread;
        #1;
    endtask

    initial begin
        // Reset
        set_id(7'b0110011, 7'd0, 5'd1, 5'd2);
        tick();
        check("reset_ex", ex_vec, V_BUB);
        check("reset_busy", {9'd0, busy_o}, 10'd0);
        check("reset_pcw", {9'd0, pc_write_o}, 10'd1);
        rst_i = 1'b1;

        // Plain decode, one per opcode class
        tick();
        check("dec_r", ex_vec, V_R);
        set_id(7'b0010011, 7'd0, 5'd1, 5'd2); tick(); check("dec_i", ex_vec, V_I);
        set_id(7'b0000011, 7'd0, 5'd1, 5'd2); tick(); check("dec_ld", ex_vec, V_LD);
        set_id(7'b0100011, 7'd0, 5'd1, 5'd2); tick(); check("dec_st", ex_vec, V_ST);
        set_id(7'b1100011, 7'd0, 5'd1, 5'd2); tick(); check("dec_br", ex_vec, V_BR);
        set_id(7'b1101111, 7'd0, 5'd1, 5'd2); tick(); check("dec_jal", ex_vec, V_JAL);
        set_id(7'b1111111, 7'd0, 5'd1, 5'd2); tick(); check("dec_other", ex_vec, V_BUB);

        // Load-use: LD x5 in EX, ADD x6,x5,x7 in ID
        set_ex(5'd5, 1'b1);
        set_id(7'b0110011, 7'd0, 5'd5, 5'd7);
        check("lu_pcw", {9'd0, pc_write_o}, 10'd0);
        check("lu_ifidw", {9'd0, ifid_write_o}, 10'd0);
        tick();
        check("lu_bubble", ex_vec, V_BUB);
        set_ex(5'd0, 1'b0);
        check("lu_release_pcw", {9'd0, pc_write_o}, 10'd1);
        tick();
        check("lu_add", ex_vec, V_R);

        // Source-usage masking (combinational only)
        set_ex(5'd7, 1'b1);
        set_id(7'b0110011, 7'd0, 5'd1, 5'd7); check("lu_r_rs2", {9'd0, pc_write_o}, 10'd0);
        set_id(7'b0010011, 7'd0, 5'd1, 5'd7); check("lu_i_rs2_ign", {9'd0, pc_write_o}, 10'd1);
        set_id(7'b0000011, 7'd0, 5'd1, 5'd7); check("lu_ld_rs2_ign", {9'd0, pc_write_o}, 10'd1);
        set_id(7'b1101111, 7'd0, 5'd7, 5'd7); check("lu_jal_ign", {9'd0, pc_write_o}, 10'd1);
        set_id(7'b0100011, 7'd0, 5'd1, 5'd7); check("lu_st_rs2", {9'd0, pc_write_o}, 10'd0);
        set_id(7'b0010011, 7'd0, 5'd7, 5'd1); check("lu_i_rs1", {9'd0, pc_write_o}, 10'd0);

        // LD x0 in EX: no stall
        set_ex(5'd0, 1'b1);
        set_id(7'b0110011, 7'd0, 5'd0, 5'd0);
        check("lu_x0_pcw", {9'd0, pc_write_o}, 10'd1);
        tick();
        check("lu_x0_ex", ex_vec, V_R);
        set_ex(5'd0, 1'b0);

        // MUL, MUL_LAT=4: 3 busy cycles / 3 bubbles
        set_id(7'b0110011, 7'b0000001, 5'd1, 5'd2);
        tick();
        check("mul_ex", ex_vec, V_MUL);
        set_id(7'b0010011, 7'd0, 5'd3, 5'd4);
        check("mul_busy0", {busy_o, pc_write_o, 8'd0}, {1'b1, 1'b0, 8'd0});
        tick();
        check("mul_bub1", ex_vec, V_BUB);
        check("mul_busy1", {busy_o, pc_write_o, 8'd0}, {1'b1, 1'b0, 8'd0});
        tick();
        check("mul_bub2", ex_vec, V_BUB);
        check("mul_busy2", {busy_o, pc_write_o, 8'd0}, {1'b1, 1'b0, 8'd0});
        tick();
        check("mul_bub3", ex_vec, V_BUB);
        check("mul_idle", {busy_o, pc_write_o, 8'd0}, {1'b0, 1'b1, 8'd0});
        tick();
        check("mul_next", ex_vec, V_I);

        // Flush coincident with load-use
        set_ex(5'd5, 1'b1);
        set_id(7'b0110011, 7'd0, 5'd5, 5'd2);
        flush_i = 1'b1;
        tick();
        check("flush_lu_bub", ex_vec, V_BUB);
        flush_i = 1'b0;
        set_ex(5'd0, 1'b0);
        set_id(7'b0010011, 7'd0, 5'd5, 5'd0);
        check("flush_lu_pcw", {9'd0, pc_write_o}, 10'd1);
        tick();
        check("flush_lu_next", ex_vec, V_I);

        // mem_stall freezes a non-bubble bundle
        set_id(7'b0100011, 7'd0, 5'd1, 5'd2);
        mem_stall_i = 1'b1;
        #1;
        check("mstall_pcw", {9'd0, pc_write_o}, 10'd0);
        tick();
        check("mstall_hold", ex_vec, V_I);
        mem_stall_i = 1'b0;
        tick();
        check("mstall_release", ex_vec, V_ST);

        // mem_stall for 2 cycles in MUL_BUSY with counter=2
        set_id(7'b0110011, 7'b0000001, 5'd1, 5'd2);
        tick();
        check("mulst_ex", ex_vec, V_MUL);
        set_id(7'b0010011, 7'd0, 5'd1, 5'd2);
        tick();
        check("mulst_cnt2", {busy_o, 9'd0}, {1'b1, 9'd0});
        mem_stall_i = 1'b1;
        tick();
        tick();
        check("mulst_frozen_busy", {busy_o, pc_write_o, 8'd0}, {1'b1, 1'b0, 8'd0});
        check("mulst_frozen_ex", ex_vec, V_BUB);
        mem_stall_i = 1'b0;
        tick();
        check("mulst_after1", {busy_o, 9'd0}, {1'b1, 9'd0});
        tick();
        check("mulst_after2", {busy_o, pc_write_o, 8'd0}, {1'b0, 1'b1, 8'd0});
        tick();
        check("mulst_next", ex_vec, V_I);

        // Flush during MUL_BUSY keeps counting
        set_id(7'b0110011, 7'b0000001, 5'd1, 5'd2);
        tick();
        set_id(7'b0100011, 7'd0, 5'd1, 5'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        check("mulfl_idle", {busy_o, 9'd0}, 10'd0);
        tick();
        check("mulfl_next", ex_vec, V_ST);

        // Reset mid-MUL_BUSY
        set_id(7'b0110011, 7'b0000001, 5'd1, 5'd2);
        tick();
        check("rstmul_busy", {busy_o, 9'd0}, {1'b1, 9'd0});
        set_id(7'b0010011, 7'd0, 5'd1, 5'd2);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("rstmul_ex", ex_vec, V_BUB);
        check("rstmul_state", {busy_o, pc_write_o, 8'd0}, {1'b0, 1'b1, 8'd0});
        tick();
        check("rstmul_next", ex_vec, V_I);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
